// File: rtl/select_accumulator_pkg.sv
// Shared configuration for the select array / accumulator slice: default
// geometry, the accumulate-stage state type and the constant-width helpers.
package select_accumulator_pkg;

  localparam int DEF_TN            = 4;
  localparam int DEF_KERNEL_SIZE   = 5;
  localparam int DEF_FEATURE_WIDTH = 16;
  localparam int DEF_BIAS_WIDTH    = 16;
  localparam int DEF_ACC_WIDTH     = 32;

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } acc_state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Number of operands left at a given adder-tree level (ceil(n / 2^level)).
  function automatic int level_count(input int n, input int level);
    return (n + (1 << level) - 1) >> level;
  endfunction

endpackage

// File: rtl/select_adder_tree.sv
// Fully pipelined unsigned adder tree: one register per level, pairwise sums,
// an odd leftover operand is carried forward registered. Latency clog2(N).
module select_adder_tree
  import select_accumulator_pkg::*;
#(
  parameter  int N         = 100,
  parameter  int IN_WIDTH  = 16,
  localparam int DEPTH     = clog2(N),
  localparam int OUT_WIDTH = IN_WIDTH + DEPTH
) (
  input  logic                  clk,
  input  logic                  in_valid,
  input  logic [N*IN_WIDTH-1:0] data_in,
  output logic [OUT_WIDTH-1:0]  sum,
  output logic                  out_valid
);

  logic [DEPTH-1:0] valid_sr;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before the edge.
  always_ff @(posedge clk) begin
    valid_sr[0] <= in_valid;
    for (int k = 1; k < DEPTH; k++) begin
      valid_sr[k] <= valid_sr[k-1];
    end
  end

  assign out_valid = valid_sr[DEPTH-1];

  // Level k holds level_count(N, k) operands, each IN_WIDTH+k bits wide.
  for (genvar k = 0; k <= DEPTH; k++) begin : lvl
    localparam int CNT = level_count(N, k);
    localparam int W   = IN_WIDTH + k;

    for (genvar i = 0; i < CNT; i++) begin : node
      logic [W-1:0] q;

      if (k == 0) begin : g_leaf
        assign q = data_in[i*IN_WIDTH +: IN_WIDTH];
      end else if (2*i + 1 < level_count(N, k-1)) begin : g_pair
        // NOTE: datapath registers carry no reset; stale contents are
        // harmless because a separately reset valid bit qualifies them.
        always_ff @(posedge clk) begin
          q <= {1'b0, lvl[k-1].node[2*i].q} + {1'b0, lvl[k-1].node[2*i+1].q};
        end
      end else begin : g_pass
        always_ff @(posedge clk) begin
          q <= {1'b0, lvl[k-1].node[2*i].q};
        end
      end
    end
  end

  assign sum = lvl[DEPTH].node[0].q;

endmodule

// File: rtl/select_accumulator.sv
// Consumer of the select array's product bus: adder-tree reduction per beat,
// saturating accumulation over first/last-framed groups, bias/shift/clamp.
module select_accumulator
  import select_accumulator_pkg::*;
#(
  parameter  int Tn            = DEF_TN,
  parameter  int KERNEL_SIZE   = DEF_KERNEL_SIZE,
  parameter  int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter  int BIAS_WIDTH    = DEF_BIAS_WIDTH,
  parameter  int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter  int OUT_SHIFT     = 0,
  localparam int NPROD         = Tn * KERNEL_SIZE * KERNEL_SIZE,
  localparam int TREE_DEPTH    = clog2(NPROD)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPROD*FEATURE_WIDTH-1:0] product_in,
  input  logic                           product_valid,
  input  logic                           first,
  input  logic                           last,
  input  logic [BIAS_WIDTH-1:0]          bias_in,
  output logic [FEATURE_WIDTH-1:0]       sum_out,
  output logic                           sum_valid,
  output logic                           err,
  output logic                           busy
);

  localparam int TREE_WIDTH = FEATURE_WIDTH + TREE_DEPTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  logic [TREE_WIDTH-1:0] tree_sum;
  logic                  tree_valid;

  select_adder_tree #(
    .N        (NPROD),
    .IN_WIDTH (FEATURE_WIDTH)
  ) u_tree (
    .clk       (clk),
    .in_valid  (product_valid),
    .data_in   (product_in),
    .sum       (tree_sum),
    .out_valid (tree_valid)
  );

  // Beat sideband travelling alongside the tree levels.
  logic [TREE_DEPTH-1:0] pipe_valid;
  logic [TREE_DEPTH-1:0] pipe_first;
  logic [TREE_DEPTH-1:0] pipe_last;
  logic [BIAS_WIDTH-1:0] pipe_bias [TREE_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= product_valid;
      for (int k = 1; k < TREE_DEPTH; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_first[0] <= first;
    pipe_last[0]  <= last;
    pipe_bias[0]  <= bias_in;
    for (int k = 1; k < TREE_DEPTH; k++) begin
      pipe_first[k] <= pipe_first[k-1];
      pipe_last[k]  <= pipe_last[k-1];
      pipe_bias[k]  <= pipe_bias[k-1];
    end
  end

  // The tree has no reset, so its own valid is only trusted together with
  // the resettable sideband copy; this drops in-flight beats on reset.
  logic beat_valid;
  logic beat_first;
  logic beat_last;

  assign beat_valid = tree_valid & pipe_valid[TREE_DEPTH-1];
  assign beat_first = pipe_first[TREE_DEPTH-1];
  assign beat_last  = pipe_last[TREE_DEPTH-1];

  // Saturating accumulate: the accumulator only ever grows, so only the
  // positive limit can be reached.
  logic [ACC_WIDTH-1:0] tree_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic [ACC_WIDTH-1:0] acc;

  assign tree_ext = ACC_WIDTH'(tree_sum);
  assign acc_sum  = {1'b0, acc} + {1'b0, tree_ext};
  assign acc_sat  = (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];

  acc_state_t state;
  logic       close_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      err     <= 1'b0;
      close_q <= 1'b0;
    end else begin
      err     <= 1'b0;
      close_q <= 1'b0;
      if (beat_valid) begin
        if (beat_first) begin
          // A first while a group is open discards that group.
          err <= (state == ST_OPEN);
          acc <= tree_ext;
          if (beat_last) begin
            close_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            state <= ST_OPEN;
          end
        end else if (state == ST_OPEN) begin
          acc <= acc_sat;
          if (beat_last) begin
            close_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // Bias of the closing beat, held for the output stage.
  logic [BIAS_WIDTH-1:0] bias_q;

  always_ff @(posedge clk) begin
    if (beat_valid && beat_last) begin
      bias_q <= pipe_bias[TREE_DEPTH-1];
    end
  end

  // Output stage: add signed bias, arithmetic shift, clamp to feature range.
  logic signed [ACC_WIDTH:0] biased;
  logic signed [ACC_WIDTH:0] shifted;
  logic [FEATURE_WIDTH-1:0]  clamped;

  assign biased  = $signed({1'b0, acc})
                 + $signed({{(ACC_WIDTH + 1 - BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q});
  assign shifted = biased >>> OUT_SHIFT;

  // NOTE: every combinational output gets a default first so no path
  // through the block can infer a latch.
  always_comb begin
    clamped = shifted[FEATURE_WIDTH-1:0];
    if (shifted[ACC_WIDTH]) begin
      clamped = '0;
    end else if (|shifted[ACC_WIDTH-1:FEATURE_WIDTH]) begin
      clamped = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= close_q;
      if (close_q) begin
        sum_out <= clamped;
      end
    end
  end

  assign busy = (state == ST_OPEN) | (|pipe_valid) | close_q;

endmodule

// File: tb/tb_select_accumulator.sv
// Self-checking bench for select_accumulator: directed scenarios plus random
// beats, checked every cycle against a group-level arithmetic model.
module tb_select_accumulator;

  localparam int  NPROD   = 100;
  localparam int  FW      = 16;
  localparam int  BW      = 16;
  localparam int  MAXC    = 8192;
  localparam longint ACC_MAX = 64'd2147483647;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NPROD*FW-1:0]   product_in = '0;
  logic                  product_valid = 1'b0;
  logic                  first = 1'b0;
  logic                  last = 1'b0;
  logic [BW-1:0]         bias_in = '0;
  logic [FW-1:0]         sum_out;
  logic                  sum_valid;
  logic                  err;
  logic                  busy;

  select_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .product_in    (product_in),
    .product_valid (product_valid),
    .first         (first),
    .last          (last),
    .bias_in       (bias_in),
    .sum_out       (sum_out),
    .sum_valid     (sum_valid),
    .err           (err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     rst_at  [MAXC];
  bit     exp_sv  [MAXC];
  bit     exp_err [MAXC];
  longint exp_val [MAXC];
  int     obs_cyc [$];
  longint obs_val [$];
  int     err_cyc [$];

  // Group-level model state.
  bit     open_grp = 1'b0;
  longint total = 0;
  longint beat_sum = 0;
  longint hold = 0;
  int     last_e = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic longint clamp_out(input longint acc_v, input longint b);
    longint t;
    t = acc_v + b;
    if (t < 0) return 0;
    if (t > 65535) return 65535;
    return t;
  endfunction

  // Edge counter; rst_at records what the DUT sampled on each edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (cyc < MAXC) rst_at[cyc] = rst;
  end

  // Per-cycle comparison against the model's expectation tables.
  initial forever begin
    @(negedge clk);
    if (cyc < MAXC) begin
      if (rst_at[cyc]) begin
        hold = 0;
        check("reset sum_valid", sum_valid, 0);
        check("reset err", err, 0);
        check("reset busy", busy, 0);
        check("reset sum_out", sum_out, 0);
      end else begin
        check("sum_valid", sum_valid, exp_sv[cyc]);
        check("err", err, exp_err[cyc]);
        if (exp_sv[cyc]) hold = exp_val[cyc];
        check("sum_out", sum_out, hold);
        if (sum_valid === 1'b1) begin
          obs_cyc.push_back(cyc);
          obs_val.push_back(longint'(sum_out));
        end
        if (err === 1'b1) err_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input int v);
    beat_sum = 0;
    for (int i = 0; i < NPROD; i++) begin
      product_in[i*FW +: FW] = FW'(v);
      beat_sum += v;
    end
  endtask

  task automatic set_rand(input int max_v);
    int v;
    beat_sum = 0;
    for (int i = 0; i < NPROD; i++) begin
      v = int'($urandom_range(0, max_v));
      product_in[i*FW +: FW] = FW'(v);
      beat_sum += v;
    end
  endtask

  // Drive one valid beat and apply the group rules to the model.
  task automatic send_beat(input bit f, input bit l, input int b);
    int e;
    product_valid = 1'b1;
    first   = f;
    last    = l;
    bias_in = BW'(b);
    e = cyc + 1;
    last_e = e;
    if (f) begin
      if (open_grp && e + 7 < MAXC) exp_err[e+7] = 1'b1;
      total    = beat_sum;
      open_grp = 1'b1;
    end else if (open_grp) begin
      total = total + beat_sum;
      if (total > ACC_MAX) total = ACC_MAX;
    end else if (e + 7 < MAXC) begin
      exp_err[e+7] = 1'b1;
    end
    if (l && open_grp) begin
      if (e + 8 < MAXC) begin
        exp_sv[e+8]  = 1'b1;
        exp_val[e+8] = clamp_out(total, longint'(b));
      end
      open_grp = 1'b0;
    end
    tick();
  endtask

  task automatic idle(input int n);
    product_valid = 1'b0;
    repeat (n) begin
      first = 1'($urandom);
      last  = 1'($urandom);
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    int e;
    rst = 1'b1;
    product_valid = 1'b0;
    e = cyc + 1;
    for (int i = e; i < MAXC; i++) begin
      exp_sv[i]  = 1'b0;
      exp_err[i] = 1'b0;
    end
    open_grp = 1'b0;
    total = 0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic clear_obs();
    obs_cyc.delete();
    obs_val.delete();
    err_cyc.delete();
  endtask

  // One strobe expected, with literal value and latency from beat edge e.
  task automatic expect_one(input string nm, input int e, input longint val);
    check({nm, " strobe count"}, obs_cyc.size(), 1);
    if (obs_cyc.size() > 0) begin
      check({nm, " latency"}, obs_cyc[0] - e, 8);
      check({nm, " value"}, obs_val[0], val);
    end
  endtask

  initial begin
    int e;
    int e2;
    int b;
    do_reset(3);
    check("busy after reset", busy, 0);

    // Single-pass group of all ones.
    clear_obs();
    set_const(1);
    send_beat(1, 1, 0);
    e = last_e;
    idle(12);
    expect_one("ones", e, 100);
    check("ones err count", err_cyc.size(), 0);

    // Two-beat group with negative bias.
    clear_obs();
    set_const(2);
    send_beat(1, 0, 0);
    set_const(3);
    send_beat(0, 1, -50);
    e = last_e;
    idle(12);
    expect_one("two beat", e, 450);

    // Upper clamp, then lower clamp.
    clear_obs();
    set_const(16'hFFFF);
    send_beat(1, 1, 0);
    e = last_e;
    idle(12);
    expect_one("upper clamp", e, 65535);
    clear_obs();
    set_const(0);
    send_beat(1, 1, -5);
    e = last_e;
    idle(12);
    expect_one("lower clamp", e, 0);

    // Orphan beat, then a group restarted by a second first.
    clear_obs();
    set_const(9);
    send_beat(0, 0, 0);
    e = last_e;
    idle(12);
    check("orphan err count", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check("orphan err latency", err_cyc[0] - e, 7);
    check("orphan no strobe", obs_cyc.size(), 0);
    clear_obs();
    set_const(7);
    send_beat(1, 0, 0);
    set_const(4);
    send_beat(1, 1, 0);
    e = last_e;
    idle(12);
    check("restart err count", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check("restart err latency", err_cyc[0] - e, 7);
    expect_one("restart", e, 400);

    // Reset one cycle after the closing beat drops the group.
    clear_obs();
    set_const(1);
    send_beat(1, 0, 0);
    send_beat(0, 0, 0);
    send_beat(0, 1, 0);
    check("busy in flight", busy, 1);
    do_reset(1);
    check("busy on reset edge", busy, 0);
    tick();
    check("busy after reset release", busy, 0);
    idle(12);
    check("reset drops strobe", obs_cyc.size(), 0);
    clear_obs();
    set_const(5);
    send_beat(1, 1, 100);
    e = last_e;
    idle(12);
    expect_one("post reset", e, 600);

    // Twenty back-to-back single-beat groups.
    clear_obs();
    e = cyc + 1;
    for (int k = 1; k <= 20; k++) begin
      set_const(k);
      send_beat(1, 1, 0);
    end
    idle(12);
    check("burst strobe count", obs_cyc.size(), 20);
    for (int i = 0; i < 20 && i < obs_cyc.size(); i++) begin
      check("burst value", obs_val[i], 100 * (i + 1));
      check("burst cycle", obs_cyc[i], e + 8 + i);
    end

    // Long group past 2^32: saturation must stop the wrap to a small value.
    clear_obs();
    set_const(16'hFFFF);
    send_beat(1, 0, 0);
    repeat (654) send_beat(0, 0, 0);
    set_const(24258);
    send_beat(0, 1, 0);
    e2 = last_e;
    idle(12);
    expect_one("saturate", e2, 65535);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        set_rand(65535);
        idle(1);
      end else begin
        if ($urandom_range(0, 3) == 0) set_rand(65535);
        else set_rand(255);
        b = int'($urandom_range(0, 65535)) - 32768;
        send_beat($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, b);
      end
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/select_accumulator.md
Name: select_accumulator

Overview:
- Consumer end of the select array's product bus.
- Each valid beat of Tn*KERNEL_SIZE*KERNEL_SIZE registered products is reduced in a pipelined adder tree.
- Tree sums are accumulated across input-channel passes framed by first/last flags.
- At the end of each group the block adds bias, shifts, clamps, and emits one FEATURE_WIDTH output pixel with a valid strobe to the output feature buffer.

Parameters:
- Tn, `Tn (4): input channels per beat
- KERNEL_SIZE, `KERNEL_SIZE (5): kernel edge
- FEATURE_WIDTH, `FEATURE_WIDTH (16): product/feature width, unsigned
- BIAS_WIDTH, `BIAS_WIDTH (16): bias width, two's complement
- ACC_WIDTH, 32: signed accumulator width
- OUT_SHIFT, 0: arithmetic right shift applied before clamp
- NPROD, Tn*KERNEL_SIZE*KERNEL_SIZE (derived, localparam): products per beat
- TREE_DEPTH, clog2(NPROD) (derived, localparam; 7 at defaults)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- product_in  in  NPROD*FEATURE_WIDTH  packed unsigned products; element i at [(i+1)*FEATURE_WIDTH-1 : i*FEATURE_WIDTH]
- product_valid  in  1  beat qualifier
- first  in  1  beat opens a group (sampled only with product_valid)
- last  in  1  beat closes a group (sampled only with product_valid)
- bias_in  in  BIAS_WIDTH  signed bias, sampled on the last beat
- sum_out  out  FEATURE_WIDTH  clamped result
- sum_valid  out  1  one-cycle strobe
- err  out  1  one-cycle protocol-error strobe
- busy  out  1  group open or pipeline non-empty

Behaviour:
- Reset is synchronous, active-high, on clk: sum_out=0, sum_valid=0, err=0, busy=0, accumulator=0, state IDLE, all pipeline valid bits cleared. Data registers need no reset.
- Reset mid-operation drops all in-flight beats; no sum_valid follows.
- Adder tree:
  - One register per level; pairwise sums.
  - Odd leftover operand passes through registered.
  - Level-k width is FEATURE_WIDTH+k; final width FEATURE_WIDTH+TREE_DEPTH.
  - Zero-extended, unsigned.
  - valid, first, last and bias travel in a shift register alongside the tree.
- Accumulate stage (1 cycle), state machine with states IDLE and OPEN:
  - IDLE, valid & first: acc <= tree sum; go OPEN. If last is also set, close immediately (single-pass group) and stay IDLE.
  - IDLE, valid & !first: beat dropped; err=1.
  - OPEN, valid & !first: acc <= sat(acc + tree). If last, close and return to IDLE.
  - OPEN, valid & first: previous group discarded; err=1; acc <= tree; treated as a new first (last handled as above).
  - sat(): clamps at 2^(ACC_WIDTH-1)-1; no wrap.
- Output stage (1 cycle, on close):
  - t = (acc_final + sign_extend(bias)) >>> OUT_SHIFT.
  - sum_out = 0 if t<0; 2^FEATURE_WIDTH-1 if t > that value; else t[FEATURE_WIDTH-1:0].
  - sum_valid=1 for exactly one cycle.
  - sum_out holds its value between strobes.
- Latency: last beat accepted at cycle T gives sum_valid at T+TREE_DEPTH+2 (T+9 at defaults).
- Throughput: one beat per cycle, no backpressure. Back-to-back groups produce back-to-back sum_valid strobes.
- busy = (state==OPEN) | any pipeline valid bit.

Decomposition:
- Shared `define header carries Tn, KERNEL_SIZE, FEATURE_WIDTH and BIAS_WIDTH, as for the select array.
- ACC_WIDTH default and a CLOG2 function go into the same header.
- One sub-module, select_adder_tree: parameters N and IN_WIDTH; ports clk, in_valid, data_in, sum, out_valid; fixed latency clog2(N).
- Accumulator FSM and output clamp stay in select_accumulator.

Test Plan:
- All 100 products=1, first=last=1, bias=0 -> sum_out=100, sum_valid exactly 9 cycles after the beat, err=0.
- Beat A all 2 (first), beat B all 3 (last) on consecutive cycles, bias=-50 -> sum_out=450, one strobe, 9 cycles after B.
- All products=0xFFFF, first=last, bias=0 -> sum 6553500 clamps to sum_out=65535. Then all products=0 with bias=-5 -> sum_out=0.
- Beat with first=0 while IDLE -> err pulse 8 cycles later, no sum_valid. Then first on group 1, then first again without last -> second err, and only the second group's result is emitted.
- Group of 3 beats (first, mid, last); rst asserted 1 cycle after the last beat -> no sum_valid, busy=0 the cycle after reset. A fresh single-beat group then returns the correct result.
- 20 consecutive single-beat groups, values k=1..20 per product -> 20 back-to-back strobes with sum_out=100*k, in order.
